toggle_event_rx: RTL and testbench
==================================

TOGGLE_EVENT_RX -- requirements
Module: toggle_event_rx

Interface
REQ-001 The block SHALL have parameter CNT_W, default 4, setting the pending-event counter width (max pending = 2^CNT_W-1).
REQ-002 The block SHALL have parameter TOT_W, default 8, setting the total-event counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 tog_in  input  1  event line from the far-end T-flip-flop transmitter; each level change is one event.
REQ-006 evt_ready  input  1  consumer accepts one event this cycle.
REQ-007 ovf_clr  input  1  clears sticky overflow flag.
REQ-008 evt_valid  output  1  at least one event pending.
REQ-009 evt_pending  output  CNT_W  number of pending, unconsumed events.
REQ-010 ovf  output  1  sticky: an event was lost to saturation.
REQ-011 evt_total  output  TOT_W  count of all detected events, modulo 2^TOT_W.

Function
REQ-012 The block SHALL register the sampled tog_in level as prev each cycle and flag an edge when the current sampled level differs from prev.
REQ-013 Rising and falling transitions of tog_in SHALL each count as exactly one event.
REQ-014 evt_pending SHALL be a register; evt_valid SHALL be combinational (evt_pending != 0).
REQ-015 Consume SHALL occur on a cycle with evt_valid=1 and evt_ready=1; evt_ready with evt_valid=0 SHALL have no effect.
REQ-016 Edge without consume: evt_pending +1. Consume without edge: evt_pending -1. Edge and consume in the same cycle: evt_pending unchanged.
REQ-017 Edge with evt_pending = 2^CNT_W-1 and no consume: evt_pending SHALL stay saturated and ovf SHALL be set at the next edge.
REQ-018 ovf SHALL stay set until ovf_clr or rst. If ovf_clr and a new overflow occur in the same cycle, set SHALL win.
REQ-019 evt_total SHALL increment by 1 on every detected edge, including lost (overflow) edges, and wrap from 2^TOT_W-1 to 0.
REQ-020 Latency with TOGGLE_SYNC_EN: a tog_in change set up before rising edge N SHALL produce evt_valid=1 after edge N+2.
REQ-021 tog_in SHALL change at most once per 3 clk cycles. Faster toggling is outside the contract, and events may be lost without ovf.

Reset
REQ-022 While rst=1 at a rising edge: evt_pending=0, evt_valid=0, ovf=0, evt_total=0, and synchronizer flops and prev=0.
REQ-023 Reset mid-operation SHALL discard all pending events. rst SHALL take priority over edge, consume and ovf_clr.
REQ-024 The transmitter holds tog_in=0 in reset. A tog_in of 1 after reset release SHALL be counted as one event.

Configuration
REQ-025 Macro TOGGLE_SYNC_EN defined: tog_in passes through a 2-flop synchronizer before edge detection, giving a latency of 3 edges (REQ-020).
REQ-026 Macro TOGGLE_SYNC_EN undefined: tog_in is sampled by a single flop, giving a latency of 2 edges. The transmitter must then be in the clk domain.

Structure
REQ-027 Package toggle_pkg SHALL hold the default widths (CNT_W_DEF=4, TOT_W_DEF=8) and the max-pending constant function.
REQ-028 Sub-module toggle_sync SHALL contain the synchronizer/sample flops, prev and the edge output. The counter, handshake and overflow logic SHALL remain in toggle_event_rx.

Verification
REQ-029 Check reset and first event:
- Stimulus: rst=1 for 2 cycles, then tog_in 0->1 with evt_ready=0.
- Response: all outputs are 0 during reset; evt_pending=1 and evt_total=1 three edges later (sync on).
REQ-030 Check counting without consumption:
- Stimulus: 5 toggles spaced 4 cycles apart, evt_ready=0.
- Response: evt_pending=5, evt_total=5, ovf=0.
REQ-031 Check drain and simultaneous edge/consume:
- Stimulus: with evt_pending=3, hold evt_ready=1 and toggle once during the drain.
- Response: one cycle shows an unchanged count; evt_pending reaches 0 after 3 consuming cycles plus 1; evt_valid=0.
REQ-032 Check saturation and overflow:
- Stimulus: 17 toggles with CNT_W=4, evt_ready=0.
- Response: evt_pending=15, ovf=1, evt_total=17.
- Then: pulse ovf_clr -> ovf=0. Pulse ovf_clr on the same cycle as an 18th overflowing edge -> ovf=1.
REQ-033 Check total-counter wrap:
- Stimulus: 256 toggles with TOT_W=8, evt_ready=1.
- Response: evt_total wraps to 0 and evt_pending=0.
REQ-034 Check reset mid-operation:
- Stimulus: assert rst with evt_pending=7 and ovf=1.
- Response: after the edge, evt_pending=0, ovf=0, evt_total=0.
- Repeat with TOGGLE_SYNC_EN undefined and check 2-edge latency.

Source files
------------

// File: rtl/toggle_pkg.sv
// toggle_pkg: default widths, pending-counter actions and the saturation limit helper
package toggle_pkg;
    localparam int CNT_W_DEF = 4;
    localparam int TOT_W_DEF = 8;
    typedef enum logic [1:0] {ACT_HOLD, ACT_INC, ACT_DEC} act_e;
    function automatic int unsigned max_pending(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction
endpackage

// File: rtl/toggle_sync.sv
// toggle_sync: samples tog_in (2-flop synchronizer when TOGGLE_SYNC_EN is defined) and flags level changes
module toggle_sync (
    input  logic clk,
    input  logic rst,
    input  logic tog_in,
    output logic edge_det
);
    logic smp;
    logic prev;
`ifdef TOGGLE_SYNC_EN
    logic meta;
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            smp  <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= tog_in;
            smp  <= meta;
            prev <= smp;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            smp  <= 1'b0;
            prev <= 1'b0;
        end else begin
            smp  <= tog_in;
            prev <= smp;
        end
    end
`endif
    assign edge_det = smp ^ prev;
endmodule

// File: rtl/toggle_event_rx.sv
// toggle_event_rx: counts tog_in level changes as events with a saturating pending count, sticky overflow and a wrapping total; TOGGLE_SYNC_EN adds input synchronization
module toggle_event_rx
    import toggle_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int TOT_W = TOT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tog_in,
    input  logic             evt_ready,
    input  logic             ovf_clr,
    output logic             evt_valid,
    output logic [CNT_W-1:0] evt_pending,
    output logic             ovf,
    output logic [TOT_W-1:0] evt_total
);
    localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(max_pending(CNT_W));
    logic edge_det;
    logic consume;
    logic lost;
    act_e act;
    toggle_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .tog_in   (tog_in),
        .edge_det (edge_det)
    );
    assign evt_valid = evt_pending != '0;
    assign consume   = evt_valid & evt_ready;
    // an edge that cannot be stored and is not offset by a consume is lost
    assign lost      = edge_det & ~consume & (evt_pending == PEND_MAX);
    always_comb begin
        act = (edge_det && !consume && !lost) ? ACT_INC :
              (consume && !edge_det) ? ACT_DEC : ACT_HOLD;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_pending <= '0;
            ovf         <= 1'b0;
            evt_total   <= '0;
        end else begin
            evt_pending <= act == ACT_INC ? evt_pending + CNT_W'(1) :
                           act == ACT_DEC ? evt_pending - CNT_W'(1) : evt_pending;
            ovf         <= lost ? 1'b1 : ovf_clr ? 1'b0 : ovf;
            evt_total   <= evt_total + TOT_W'(edge_det);
        end
    end
endmodule

// File: tb/tb_toggle_event_rx.sv
// tb_toggle_event_rx: scoreboard bench; event arrival times are modelled as a queue of future cycle numbers
module tb_toggle_event_rx;
    localparam int MAXP = 15;
`ifdef TOGGLE_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 1;
`endif
    typedef struct {
        int pend;
        logic ovf;
        int tot;
    } exp_t;

    logic clk = 1'b0;
    logic rst, tog_in, evt_ready, ovf_clr;
    logic evt_valid, ovf;
    logic [3:0] evt_pending;
    logic [7:0] evt_total;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int m_pend = 0;
    int m_tot = 0;
    logic m_ovf = 1'b0;
    logic tog = 1'b0;
    logic tog_q = 1'b0;
    int arr[$];
    exp_t exp_q[$];

    toggle_event_rx #(.CNT_W(4), .TOT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .tog_in      (tog_in),
        .evt_ready   (evt_ready),
        .ovf_clr     (ovf_clr),
        .evt_valid   (evt_valid),
        .evt_pending (evt_pending),
        .ovf         (ovf),
        .evt_total   (evt_total)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("evt_pending", 32'(evt_pending), 32'(e.pend));
            chk("evt_valid", 32'(evt_valid), 32'(e.pend != 0));
            chk("ovf", 32'(ovf), 32'(e.ovf));
            chk("evt_total", 32'(evt_total), 32'(e.tot));
        end
    end

    // one clock: apply inputs, advance the reference model, queue the expected outputs
    task automatic step(input logic r, input logic c, input logic rs);
        logic ev, cons;
        if (rs) tog = 1'b0;
        tog_in = tog;
        evt_ready = r;
        ovf_clr = c;
        rst = rs;
        if (rs) begin
            m_pend = 0;
            m_tot = 0;
            m_ovf = 1'b0;
            arr.delete();
        end else begin
            if (tog != tog_q) arr.push_back(cyc + D);
            ev = arr.size() > 0 && arr[0] == cyc;
            if (ev) void'(arr.pop_front());
            cons = m_pend != 0 && r;
            if (ev) m_tot = (m_tot + 1) % 256;
            if (c) m_ovf = 1'b0;
            if (ev && !cons) begin
                if (m_pend == MAXP) m_ovf = 1'b1;
                else m_pend++;
            end
            if (cons && !ev) m_pend--;
        end
        tog_q = tog;
        cyc++;
        @(posedge clk);
        exp_q.push_back('{m_pend, m_ovf, m_tot});
        #1;
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step(r, 1'b0, 1'b0);
    endtask

    task automatic toggle(input int gap, input logic r);
        tog = ~tog;
        step(r, 1'b0, 1'b0);
        idle(gap - 1, r);
    endtask

    task automatic reset(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int since, gap;
        reset(2);
        toggle(5, 1'b0);
        for (int i = 0; i < 4; i++) toggle(4, 1'b0);
        idle(3, 1'b0);

        reset(1);
        for (int i = 0; i < 3; i++) toggle(4, 1'b0);
        idle(2, 1'b0);
        toggle(3, 1'b1);
        idle(6, 1'b1);

        reset(1);
        for (int i = 0; i < 17; i++) toggle(3, 1'b0);
        idle(3, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        idle(2, 1'b0);
        tog = ~tog;
        step(1'b0, 1'b0, 1'b0);
        idle(D - 1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        idle(3, 1'b0);

        reset(1);
        for (int i = 0; i < 256; i++) toggle(3, 1'b1);
        idle(4, 1'b1);

        reset(1);
        for (int i = 0; i < 17; i++) toggle(3, 1'b0);
        idle(3, 1'b0);
        idle(8, 1'b1);
        idle(2, 1'b0);
        reset(1);
        toggle(5, 1'b0);

        since = 0;
        gap = 3;
        for (int n = 0; n < 600; n++) begin
            logic rs;
            rs = ($urandom % 100) == 0;
            since++;
            if (!rs && since >= gap) begin
                tog = ~tog;
                since = 0;
                gap = $urandom_range(3, 6);
            end
            if (rs) since = 0;
            step(1'($urandom % 2), 1'(($urandom % 16) == 0), rs);
        end
        idle(4, 1'b0);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
